// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by fetch, imm_Gen and the control decoder.
// Holds the canonical NOP, datapath width, major opcodes and the fetch-queue entry type.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b000_0011,
    OPC_OP_IMM = 7'b001_0011,
    OPC_STORE  = 7'b010_0011,
    OPC_LUI    = 7'b011_0111,
    OPC_BRANCH = 7'b110_0011,
    OPC_JALR   = 7'b110_0111,
    OPC_JAL    = 7'b110_1111
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries between instruction memory and decode.
// Flush empties it in one cycle; push and pop together are legal even when full.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left without reset; validity is tracked by count,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues word reads to a 1-cycle synchronous
// instruction memory, and queues {pc, inst} for decode with redirect flush support.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;

  logic          pop;
  logic          push;
  logic [CW-1:0] count;
  logic          empty;
  logic [CW:0]   occupancy;
  fetch_entry_t  head;
  fetch_entry_t  tail;

  assign pop = inst_valid & inst_ready;

  // Credit: queued words plus the outstanding read, less what decode takes this cycle,
  // must leave room for the word a new request will return.
  always_comb begin
    occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_req  = reset && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
  end

  // A response landing in a redirect cycle belongs to the abandoned path.
  assign push = inflight_q && !redirect_valid;
  assign tail = '{pc: inflight_pc_q, inst: imem_rdata};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & ~32'd3;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      if (imem_req) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (tail),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  assign imem_addr  = pc_q;
  assign inst_valid = !empty;
  assign inst_code  = empty ? NOP_INST : head.inst;
  assign inst_pc    = empty ? 32'd0    : head.pc;

endmodule
